// File: rtl/codificador_bcd_binario.sv
// BCD-to-binary converter using reverse double dabble.
// One shift+adjust step per clock; the result saturates when it does not fit in ANCHO_BIN bits.
module codificador_bcd_binario #(
    parameter int unsigned N_DIGITOS = 3,
    parameter int unsigned ANCHO_BIN = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inicio,
    input  logic [4*N_DIGITOS-1:0] bcd_entrada,
    output logic [ANCHO_BIN-1:0]   valor_binario,
    output logic                   listo,
    output logic                   ocupado,
    output logic                   error_digito,
    output logic                   desbordamiento
);

    localparam int unsigned ANCHO_BCD = 4 * N_DIGITOS;
    localparam int unsigned ANCHO_SR  = ANCHO_BCD + ANCHO_BIN;
    localparam int unsigned ANCHO_IT  = $clog2(ANCHO_BIN + 1);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] CONVIERTE = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [ANCHO_SR-1:0] sr_q, sr_d;
    logic [ANCHO_IT-1:0] it_q, it_d;
    logic [ANCHO_BIN-1:0] valor_q, valor_d;
    logic                listo_q, listo_d;
    logic                ocupado_q, ocupado_d;
    logic                error_q, error_d;
    logic                desb_q, desb_d;

    logic                digito_invalido_c;
    logic [ANCHO_SR-1:0] desplazado_c;
    logic [ANCHO_SR-1:0] paso_c;

    // Flags any input digit above 9
    always_comb begin
        digito_invalido_c = 1'b0;
        for (int i = 0; i < int'(N_DIGITOS); i++) begin
            if (bcd_entrada[4*i +: 4] > 4'd9) begin
                digito_invalido_c = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift right, then -3 on every BCD nibble >= 8
    always_comb begin
        desplazado_c = sr_q >> 1;
        paso_c       = desplazado_c;
        for (int i = 0; i < int'(N_DIGITOS); i++) begin
            if (desplazado_c[ANCHO_BIN + 4*i +: 4] >= 4'd8) begin
                paso_c[ANCHO_BIN + 4*i +: 4] = desplazado_c[ANCHO_BIN + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        it_d      = it_q;
        valor_d   = valor_q;
        listo_d   = 1'b0;
        ocupado_d = ocupado_q;
        error_d   = error_q;
        desb_d    = desb_q;

        case (state_q)
            IDLE: begin
                if (inicio) begin
                    if (digito_invalido_c) begin
                        valor_d = '0;
                        error_d = 1'b1;
                        desb_d  = 1'b0;
                        listo_d = 1'b1;
                    end else begin
                        sr_d      = {bcd_entrada, {ANCHO_BIN{1'b0}}};
                        it_d      = '0;
                        state_d   = CONVIERTE;
                        ocupado_d = 1'b1;
                    end
                end
            end
            CONVIERTE: begin
                sr_d = paso_c;
                it_d = it_q + ANCHO_IT'(1);
                if (it_q == ANCHO_IT'(ANCHO_BIN - 1)) begin
                    state_d   = IDLE;
                    ocupado_d = 1'b0;
                    listo_d   = 1'b1;
                    error_d   = 1'b0;
                    if (paso_c[ANCHO_SR-1:ANCHO_BIN] == '0) begin
                        valor_d = paso_c[ANCHO_BIN-1:0];
                        desb_d  = 1'b0;
                    end else begin
                        valor_d = '1;
                        desb_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                ocupado_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            it_q      <= '0;
            valor_q   <= '0;
            listo_q   <= 1'b0;
            ocupado_q <= 1'b0;
            error_q   <= 1'b0;
            desb_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            it_q      <= it_d;
            valor_q   <= valor_d;
            listo_q   <= listo_d;
            ocupado_q <= ocupado_d;
            error_q   <= error_d;
            desb_q    <= desb_d;
        end
    end

    assign valor_binario  = valor_q;
    assign listo          = listo_q;
    assign ocupado        = ocupado_q;
    assign error_digito   = error_q;
    assign desbordamiento = desb_q;

endmodule

// File: tb/tb_codificador_bcd_binario.sv
// Bench for codificador_bcd_binario: directed cases plus random BCD words,
// checked against a decimal-arithmetic reference model. Two instances (8- and 10-bit).
module tb_codificador_bcd_binario;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inicio8, inicio10;
    logic [11:0] bcd8, bcd10;
    logic [7:0]  valor8;
    logic [9:0]  valor10;
    logic        listo8, listo10, ocupado8, ocupado10;
    logic        err8, err10, desb8, desb10;

    int n_checks = 0;
    int n_errors = 0;
    bit usa10 = 1'b0;

    logic [9:0] o_valor;
    logic       o_listo, o_ocupado, o_err, o_desb;

    codificador_bcd_binario #(.N_DIGITOS(3), .ANCHO_BIN(8)) dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio8), .bcd_entrada(bcd8),
        .valor_binario(valor8), .listo(listo8), .ocupado(ocupado8),
        .error_digito(err8), .desbordamiento(desb8)
    );

    codificador_bcd_binario #(.N_DIGITOS(3), .ANCHO_BIN(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .inicio(inicio10), .bcd_entrada(bcd10),
        .valor_binario(valor10), .listo(listo10), .ocupado(ocupado10),
        .error_digito(err10), .desbordamiento(desb10)
    );

    always #5 clk = ~clk;

    assign o_valor   = usa10 ? valor10 : {2'b00, valor8};
    assign o_listo   = usa10 ? listo10 : listo8;
    assign o_ocupado = usa10 ? ocupado10 : ocupado8;
    assign o_err     = usa10 ? err10 : err8;
    assign o_desb    = usa10 ? desb10 : desb8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value from digits, saturate at 2**w
    function automatic void modelo(input logic [11:0] bcd, input int w,
                                   output logic [9:0] val, output logic err, output logic desb);
        int v;
        int pot;
        int d;
        v = 0; pot = 1; err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = int'(bcd[4*i +: 4]);
            if (d > 9) err = 1'b1;
            v += d * pot;
            pot *= 10;
        end
        if (err) begin
            val = '0; desb = 1'b0;
        end else if (v >= (1 << w)) begin
            val = 10'((1 << w) - 1); desb = 1'b1;
        end else begin
            val = 10'(v); desb = 1'b0;
        end
    endfunction

    task automatic drive(input bit sel, input logic ini, input logic [11:0] bcd);
        if (sel) begin inicio10 = ini; bcd10 = bcd; end
        else     begin inicio8  = ini; bcd8  = bcd; end
    endtask

    // One request, optional intruder pulse while busy; checks latency, busy time, result, flags
    task automatic convertir(input bit sel, input logic [11:0] bcd, input bit inyectar,
                             input logic [11:0] intruso, input string tag);
        logic [9:0] e_val;
        logic       e_err, e_desb;
        int w, k, ocup, lat_exp;
        bit visto;
        usa10 = sel;
        w = sel ? 10 : 8;
        modelo(bcd, w, e_val, e_err, e_desb);
        lat_exp = e_err ? 0 : w;
        @(negedge clk); drive(sel, 1'b1, bcd);
        @(negedge clk); drive(sel, 1'b0, bcd);
        k = 0; ocup = 0; visto = 1'b0;
        while (k < 40 && !visto) begin
            if (inyectar && k == 2) drive(sel, 1'b1, intruso);
            if (inyectar && k == 3) drive(sel, 1'b0, intruso);
            if (o_ocupado) ocup++;
            if (o_listo) visto = 1'b1;
            else begin @(negedge clk); k++; end
        end
        chk({tag, " listo"}, 32'(visto), 32'd1);
        chk({tag, " latencia"}, 32'(k), 32'(lat_exp));
        chk({tag, " ocupado"}, 32'(ocup), 32'(lat_exp));
        chk({tag, " valor"}, 32'(o_valor), 32'(e_val));
        chk({tag, " error"}, 32'(o_err), 32'(e_err));
        chk({tag, " desb"}, 32'(o_desb), 32'(e_desb));
        @(negedge clk);
        chk({tag, " pulso"}, 32'(o_listo), 32'd0);
        chk({tag, " retenido"}, 32'(o_valor), 32'(e_val));
    endtask

    initial begin
        int cnt;
        logic [11:0] r;
        rst_n = 1'b0;
        inicio8 = 1'b0; inicio10 = 1'b0; bcd8 = '0; bcd10 = '0;
        #3;
        chk("rst valor", 32'(valor8), 32'd0);
        chk("rst flags", 32'({listo8, ocupado8, err8, desb8}), 32'd0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;

        // Abort mid-conversion with reset
        usa10 = 1'b0;
        @(negedge clk); drive(1'b0, 1'b1, 12'h200);
        @(negedge clk); drive(1'b0, 1'b0, 12'h200);
        @(negedge clk); @(negedge clk);
        chk("t1 ocupado antes", 32'(ocupado8), 32'd1);
        rst_n = 1'b0; #1;
        chk("t1 rst salidas", 32'({valor8, listo8, ocupado8, err8, desb8}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (listo8 || ocupado8) cnt++;
        end
        chk("t1 sin listo", 32'(cnt), 32'd0);
        convertir(1'b0, 12'h042, 1'b0, '0, "t1 tras rst");

        convertir(1'b0, 12'h255, 1'b0, '0, "t2 255");
        convertir(1'b0, 12'h000, 1'b0, '0, "t3 000");
        convertir(1'b0, 12'h100, 1'b0, '0, "t3 100");
        convertir(1'b0, 12'h256, 1'b0, '0, "t4 256");
        convertir(1'b0, 12'h999, 1'b0, '0, "t4 999");
        convertir(1'b0, 12'h1A3, 1'b0, '0, "t5 1A3");
        convertir(1'b0, 12'h123, 1'b1, 12'h045, "t6 intruso");
        convertir(1'b1, 12'h999, 1'b0, '0, "t7 w10 999");
        convertir(1'b1, 12'hF00, 1'b0, '0, "t7 w10 F00");

        // Random requests on both widths, occasional invalid digits
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 7) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
                else                           r[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            convertir(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)),
                      12'($urandom), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
